// File: rtl/day_of_yr_decoder.sv
// rtl/day_of_yr_decoder.sv - day-of-year to month/day-of-month decoder
// Validates against the year's length, then walks one month per clock.
module day_of_yr_decoder #(
  parameter int YEAR_W = 11
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        dayOfYear,
  input  logic [YEAR_W-1:0] year,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        month,
  output logic [5:0]        dayOfMonth,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, CHECK, WALK, DONE} state_t;

  state_t            state, state_n;
  logic [8:0]        doy_q;
  logic [YEAR_W-1:0] year_q;
  logic              leap_q;
  logic [8:0]        rem;
  logic [3:0]        cur_m;

  logic [31:0]       year_ext;
  logic              leap_c;
  logic [8:0]        year_len;
  logic              bad_doy;
  logic [8:0]        month_len;
  logic              fits;

  assign year_ext = 32'(year_q);
  assign leap_c   = (year_ext % 32'd4 == 32'd0) &&
                    ((year_ext % 32'd100 != 32'd0) || (year_ext % 32'd400 == 32'd0));
  assign year_len = leap_c ? 9'd366 : 9'd365;
  assign bad_doy  = (doy_q == 9'd0) || (doy_q > year_len);

  // February uses the leap flag registered in CHECK, not a live recompute
  always_comb begin
    month_len = 9'd31;
    case (cur_m)
      4'd2:                        month_len = 9'd28 + {8'd0, leap_q};
      4'd4, 4'd6, 4'd9, 4'd11:     month_len = 9'd30;
      default:                     month_len = 9'd31;
    endcase
  end

  assign fits = (rem <= month_len);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = CHECK;
      CHECK:   state_n = bad_doy ? DONE : WALK;
      WALK:    if (fits) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      month      <= 4'd0;
      dayOfMonth <= 6'd0;
      error      <= 1'b0;
      doy_q      <= 9'd0;
      year_q     <= '0;
      leap_q     <= 1'b0;
      rem        <= 9'd0;
      cur_m      <= 4'd0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            doy_q  <= dayOfYear;
            year_q <= year;
          end
        end
        CHECK: begin
          leap_q <= leap_c;
          if (bad_doy) begin
            month      <= 4'd0;
            dayOfMonth <= 6'd0;
            error      <= 1'b1;
          end else begin
            rem   <= doy_q;
            cur_m <= 4'd1;
          end
        end
        WALK: begin
          if (fits) begin
            month      <= cur_m;
            dayOfMonth <= rem[5:0];
            error      <= 1'b0;
          end else begin
            rem   <= rem - month_len;
            cur_m <= cur_m + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_day_of_yr_decoder.sv
// tb/tb_day_of_yr_decoder.sv - self-checking bench for day_of_yr_decoder
// Reference model steps a calendar date forward one day at a time.
module tb_day_of_yr_decoder;

  logic        clk = 1'b0;
  logic        resetN;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  dayOfYear;
  logic [10:0] year;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  month;
  logic [5:0]  dayOfMonth;
  logic        error;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  day_of_yr_decoder #(.YEAR_W(11)) dut (
    .clk(clk), .resetN(resetN), .in_valid(in_valid), .in_ready(in_ready),
    .dayOfYear(dayOfYear), .year(year), .out_valid(out_valid), .out_ready(out_ready),
    .month(month), .dayOfMonth(dayOfMonth), .error(error)
  );

  typedef struct {
    int doy; int yr; int mo; int dm; int err; int lat;
  } vec_t;

  vec_t vecs[11];
  int   base_len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic int is_leap(input int y);
    return ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) ? 1 : 0;
  endfunction

  function automatic int mlen(input int mo, input int leap);
    return base_len[mo-1] + ((mo == 2) ? leap : 0);
  endfunction

  function automatic void ref_decode(input int d, input int y,
                                     output int mo, output int dm, output int e);
    int leap;
    leap = is_leap(y);
    if (d < 1 || d > 365 + leap) begin
      mo = 0; dm = 0; e = 1;
    end else begin
      mo = 1; dm = 1; e = 0;
      for (int i = 1; i < d; i++) begin
        dm++;
        if (dm > mlen(mo, leap)) begin
          dm = 1;
          mo++;
        end
      end
    end
  endfunction

  function automatic int forward(input int mo, input int dm, input int y);
    int acc;
    acc = dm;
    for (int i = 1; i < mo; i++) acc += mlen(i, is_leap(y));
    return acc;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one request with out_ready high; returns after the retiring edge.
  task automatic run_req(input int d, input int y, output int mo, output int dm,
                         output int e, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    in_valid  = 1'b1;
    dayOfYear = 9'(d);
    year      = 11'(y);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    dayOfYear = 9'($urandom);
    year      = 11'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    mo = int'(month);
    dm = int'(dayOfMonth);
    e  = int'(error);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mo, dm, e, lat, rmo, rdm, re, d, y, saw;
    int years[$];

    vecs[0]  = '{60,  2000, 2,  29, 0, 3};
    vecs[1]  = '{60,  1900, 3,  1,  0, 4};
    vecs[2]  = '{366, 1900, 0,  0,  1, 1};
    vecs[3]  = '{366, 0,    12, 31, 0, 13};
    vecs[4]  = '{365, 2047, 12, 31, 0, 13};
    vecs[5]  = '{0,   2047, 0,  0,  1, 1};
    vecs[6]  = '{1,   2023, 1,  1,  0, 2};
    vecs[7]  = '{367, 2000, 0,  0,  1, 1};
    vecs[8]  = '{366, 2000, 12, 31, 0, 13};
    vecs[9]  = '{59,  1900, 2,  28, 0, 3};
    vecs[10] = '{511, 5,    0,  0,  1, 1};

    resetN = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dayOfYear = 9'd0; year = 11'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_month", int'(month), 0);
    check("reset_dom", int'(dayOfMonth), 0);
    check("reset_error", int'(error), 0);
    @(negedge clk) resetN = 1'b1;

    foreach (vecs[i]) begin
      run_req(vecs[i].doy, vecs[i].yr, mo, dm, e, lat);
      check($sformatf("vec%0d_month", i), mo, vecs[i].mo);
      check($sformatf("vec%0d_dom", i), dm, vecs[i].dm);
      check($sformatf("vec%0d_error", i), e, vecs[i].err);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_retire_valid", i), int'(out_valid), 0);
      check($sformatf("vec%0d_retire_ready", i), int'(in_ready), 1);
    end

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; dayOfYear = 9'd32; year = 11'd2024;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_month", int'(month), 2);
      check("bp_dom", int'(dayOfMonth), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);

    // Asynchronous reset while walking (October needs edges up to E11)
    @(negedge clk);
    in_valid = 1'b1; dayOfYear = 9'd300; year = 11'd2023;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetN = 1'b0;
    #1;
    check("rst_walk_month", int'(month), 0);
    check("rst_walk_dom", int'(dayOfMonth), 0);
    check("rst_walk_error", int'(error), 0);
    check("rst_walk_out_valid", int'(out_valid), 0);
    check("rst_walk_in_ready", int'(in_ready), 1);
    @(negedge clk) resetN = 1'b1;
    saw = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1;
    end
    check("rst_walk_no_result", saw, 0);

    for (int i = 0; i < 100; i++) begin
      y = int'($urandom_range(0, 2047));
      d = int'($urandom_range(0, 370));
      ref_decode(d, y, rmo, rdm, re);
      run_req(d, y, mo, dm, e, lat);
      check($sformatf("rand_month y=%0d d=%0d", y, d), mo, rmo);
      check($sformatf("rand_dom y=%0d d=%0d", y, d), dm, rdm);
      check($sformatf("rand_error y=%0d d=%0d", y, d), e, re);
      check($sformatf("rand_latency y=%0d d=%0d", y, d), lat, (re != 0) ? 1 : rmo + 1);
    end

    for (int yy = 0; yy <= 2047; yy += 100) years.push_back(yy);
    years.push_back(2004);
    years.push_back(2047);
    foreach (years[k]) begin
      for (int dd = 1; dd <= 365 + is_leap(years[k]); dd++) begin
        run_req(dd, years[k], mo, dm, e, lat);
        check($sformatf("rt_error y=%0d d=%0d", years[k], dd), e, 0);
        check($sformatf("rt_doy y=%0d d=%0d", years[k], dd), forward(mo, dm, years[k]), dd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
